// File: rtl/bus_decoder.sv
// CPU address decoder for RAM, ROM and a window of 256-byte I/O pages, with
// per-slot wait-state handshakes, an optional read register and a bus timeout.
module bus_decoder #(
   parameter int                NSLOTS   = 8,
   parameter logic [7:0]        IO_PAGE  = 8'hD0,
   parameter logic [NSLOTS-1:0] ACK_MASK = '0,
   parameter logic [NSLOTS-1:0] REG_MASK = '0,
   parameter int                TIMEOUT  = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [15:0]           cpu_next_addr,
   input  logic                  cpu_next_rd,
   input  logic                  cpu_next_we,
   output logic [7:0]            cpu_di,
   output logic                  cpu_enable,
   output logic                  ram_we,
   input  logic [7:0]            ram_data,
   input  logic [7:0]            rom_data,
   output logic [NSLOTS-1:0]     io_rd,
   output logic [NSLOTS-1:0]     io_wr,
   input  logic [8*NSLOTS-1:0]   io_data,
   input  logic [NSLOTS-1:0]     io_ack,
   output logic                  bus_err,
   output logic [15:0]           err_addr,
   input  logic                  err_clr,
   output logic [0:0]            fsm_state
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   localparam logic [2:0] SRC_NONE = 3'd0;
   localparam logic [2:0] SRC_RAM  = 3'd1;
   localparam logic [2:0] SRC_ROM  = 3'd2;
   localparam logic [2:0] SRC_SLOT = 3'd3;
   localparam logic [2:0] SRC_ERR  = 3'd4;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   logic [0:0] state;
   logic [7:0] wcnt;
   logic [2:0] sel_kind;
   logic [3:0] sel_slot;
   logic [7:0] slot_q [NSLOTS];

   logic       ram_hit, rom_hit, slot_hit;
   logic [7:0] slot_diff;
   logic       slot_ack, slot_stalls;
   logic       stall_req, timeout_hit;
   logic [2:0] dec_kind;

   assign fsm_state = state;

   // Priority RAM > ROM > I/O window falls out of masking the window hit.
   assign ram_hit   = ~cpu_next_addr[15];
   assign rom_hit   = (cpu_next_addr[15:13] == 3'b111);
   assign slot_diff = cpu_next_addr[15:8] - IO_PAGE;
   assign slot_hit  = ~ram_hit & ~rom_hit & (cpu_next_addr[15:8] >= IO_PAGE)
                      & ({1'b0, slot_diff} < 9'(NSLOTS));

   always_comb begin
      slot_ack    = 1'b0;
      slot_stalls = 1'b0;
      io_rd       = '0;
      io_wr       = '0;
      for (int k = 0; k < NSLOTS; k++) begin
         if (slot_diff == 8'(k)) begin
            slot_ack    = io_ack[k];
            slot_stalls = ACK_MASK[k];
         end
         io_rd[k] = ~reset & slot_hit & cpu_next_rd & (slot_diff == 8'(k));
         io_wr[k] = ~reset & slot_hit & cpu_next_we & (slot_diff == 8'(k));
      end
   end

   assign ram_we = ~reset & ram_hit & cpu_next_we;

   // The same condition that starts a stall keeps it going; its absence in WAIT is the ack.
   assign stall_req   = slot_hit & slot_stalls & (cpu_next_rd | cpu_next_we) & ~slot_ack;
   assign timeout_hit = (state == ST_WAIT) & stall_req & (wcnt >= TIMEOUT_C);
   assign cpu_enable  = ~reset & (~stall_req | timeout_hit);

   always_comb begin
      dec_kind = SRC_NONE;
      if (cpu_next_rd) begin
         if (ram_hit)       dec_kind = SRC_RAM;
         else if (rom_hit)  dec_kind = SRC_ROM;
         else if (slot_hit) dec_kind = SRC_SLOT;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         wcnt     <= 8'd0;
         sel_kind <= SRC_NONE;
         sel_slot <= 4'd0;
         bus_err  <= 1'b0;
         err_addr <= 16'h0000;
      end else begin
         case (state)
            ST_IDLE: begin
               if (stall_req) begin
                  state <= ST_WAIT;
                  wcnt  <= 8'd1;
               end
            end
            default: begin
               if (!stall_req || timeout_hit) begin
                  state <= ST_IDLE;
                  wcnt  <= 8'd0;
               end else begin
                  wcnt  <= wcnt + 8'd1;
               end
            end
         endcase

         if (timeout_hit) begin
            sel_kind <= SRC_ERR;
            bus_err  <= 1'b1;
            err_addr <= cpu_next_addr;
         end else begin
            if (cpu_enable) begin
               sel_kind <= dec_kind;
               sel_slot <= slot_diff[3:0];
            end
            if (err_clr) bus_err <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NSLOTS; k++) slot_q[k] <= 8'h00;
      end else begin
         for (int k = 0; k < NSLOTS; k++) slot_q[k] <= io_data[8*k +: 8];
      end
   end

   always_comb begin
      cpu_di = 8'h00;
      case (sel_kind)
         SRC_RAM: cpu_di = ram_data;
         SRC_ROM: cpu_di = rom_data;
         SRC_ERR: cpu_di = 8'hFF;
         SRC_SLOT: begin
            for (int k = 0; k < NSLOTS; k++) begin
               if (sel_slot == 4'(k)) cpu_di = REG_MASK[k] ? slot_q[k] : io_data[8*k +: 8];
            end
         end
         default: cpu_di = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_bus_decoder.sv
// Directed bench for bus_decoder: a vector table of single-cycle accesses plus
// hand sequences for wait states, timeouts, error clearing and reset aborts.
module tb_bus_decoder;

   logic        clk;
   logic        reset;
   logic [15:0] cpu_next_addr;
   logic        cpu_next_rd;
   logic        cpu_next_we;
   logic [7:0]  cpu_di;
   logic        cpu_enable;
   logic        ram_we;
   logic [7:0]  ram_data;
   logic [7:0]  rom_data;
   logic [7:0]  io_rd;
   logic [7:0]  io_wr;
   logic [63:0] io_data;
   logic [7:0]  io_ack;
   logic        bus_err;
   logic [15:0] err_addr;
   logic        err_clr;
   logic [0:0]  fsm_state;

   int n_checks = 0;
   int n_errors = 0;

   bus_decoder #(
      .NSLOTS(8), .IO_PAGE(8'hD0), .ACK_MASK(8'h02), .REG_MASK(8'h20), .TIMEOUT(4)
   ) dut (
      .clk(clk), .reset(reset), .cpu_next_addr(cpu_next_addr), .cpu_next_rd(cpu_next_rd),
      .cpu_next_we(cpu_next_we), .cpu_di(cpu_di), .cpu_enable(cpu_enable), .ram_we(ram_we),
      .ram_data(ram_data), .rom_data(rom_data), .io_rd(io_rd), .io_wr(io_wr),
      .io_data(io_data), .io_ack(io_ack), .bus_err(bus_err), .err_addr(err_addr),
      .err_clr(err_clr), .fsm_state(fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] addr;
      logic        rd;
      logic        we;
      logic        exp_ram_we;
      logic [7:0]  exp_rd;
      logic [7:0]  exp_wr;
      logic        exp_en;
      logic [7:0]  exp_di;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [15:0] a, input logic rd, input logic we);
      cpu_next_addr = a;
      cpu_next_rd   = rd;
      cpu_next_we   = we;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   initial begin
      vecs[0]  = '{"wr_ram_1234",  16'h1234, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 8'h00};
      vecs[1]  = '{"rd_ram_1234",  16'h1234, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h5A};
      vecs[2]  = '{"rd_slot3",     16'hD342, 1'b1, 1'b0, 1'b0, 8'h08, 8'h00, 1'b1, 8'hA5};
      vecs[3]  = '{"wr_slot3",     16'hD300, 1'b0, 1'b1, 1'b0, 8'h00, 8'h08, 1'b1, 8'h00};
      vecs[4]  = '{"rd_unmap_9000",16'h9000, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00};
      vecs[5]  = '{"rd_out_d800",  16'hD800, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00};
      vecs[6]  = '{"rd_rom_f000",  16'hF000, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hC3};
      vecs[7]  = '{"rd_rom_e000",  16'hE000, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hC3};
      vecs[8]  = '{"rd_slot7",     16'hD700, 1'b1, 1'b0, 1'b0, 8'h80, 8'h00, 1'b1, 8'h37};
      vecs[9]  = '{"rd_ram_7fff",  16'h7FFF, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h5A};
      vecs[10] = '{"wr_slot0",     16'hD000, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b1, 8'h00};
      vecs[11] = '{"noacc_slot1",  16'hD100, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00};
      vecs[12] = '{"wr_rom_f000",  16'hF000, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00};
      vecs[13] = '{"rd_slot5_reg", 16'hD500, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 1'b1, 8'h35};

      ram_data = 8'h5A;
      rom_data = 8'hC3;
      for (int k = 0; k < 8; k++) io_data[8*k +: 8] = 8'h30 + 8'(k);
      io_data[31:24] = 8'hA5;
      io_ack  = 8'h00;
      err_clr = 1'b0;

      // Reset state, with an access applied to show strobes are gated.
      reset = 1'b1;
      drive(16'h1234, 1'b0, 1'b1);
      #2;
      chk("rst_ram_we", 32'(ram_we), 32'h0);
      chk("rst_en", 32'(cpu_enable), 32'h0);
      drive(16'hD100, 1'b1, 1'b0);
      #1;
      chk("rst_io_rd", 32'(io_rd), 32'h0);
      chk("rst_en_stallslot", 32'(cpu_enable), 32'h0);
      tick();
      tick();
      chk("rst_di", 32'(cpu_di), 32'h00);
      chk("rst_bus_err", 32'(bus_err), 32'h0);
      chk("rst_err_addr", 32'(err_addr), 32'h0);
      chk("rst_state", 32'(fsm_state), 32'h0);
      drive(16'h0000, 1'b0, 1'b0);
      reset = 1'b0;

      // Single-cycle accesses from the table.
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].addr, vecs[i].rd, vecs[i].we);
         sample();
         chk({vecs[i].name, "_ram_we"}, 32'(ram_we), 32'(vecs[i].exp_ram_we));
         chk({vecs[i].name, "_io_rd"}, 32'(io_rd), 32'(vecs[i].exp_rd));
         chk({vecs[i].name, "_io_wr"}, 32'(io_wr), 32'(vecs[i].exp_wr));
         chk({vecs[i].name, "_en"}, 32'(cpu_enable), 32'(vecs[i].exp_en));
         tick();
         drive(16'h0000, 1'b0, 1'b0);
         sample();
         chk({vecs[i].name, "_di"}, 32'(cpu_di), 32'(vecs[i].exp_di));
         tick();
      end

      // Wait-state read of slot 1, ack after three stall cycles.
      drive(16'hD100, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         sample();
         chk("ack_stall_en", 32'(cpu_enable), 32'h0);
         chk("ack_stall_io_rd", 32'(io_rd), 32'h02);
         tick();
      end
      io_ack = 8'h02;
      sample();
      chk("ack_cycle_en", 32'(cpu_enable), 32'h1);
      chk("ack_cycle_io_rd", 32'(io_rd), 32'h02);
      chk("ack_cycle_state", 32'(fsm_state), 32'h1);
      tick();
      io_ack = 8'h00;
      drive(16'h0000, 1'b0, 1'b0);
      sample();
      chk("ack_di", 32'(cpu_di), 32'h31);
      chk("ack_bus_err", 32'(bus_err), 32'h0);
      chk("ack_state", 32'(fsm_state), 32'h0);
      tick();

      // Timeout: no ack ever.
      drive(16'hD100, 1'b1, 1'b0);
      for (int c = 0; c < 4; c++) begin
         sample();
         chk("to_stall_en", 32'(cpu_enable), 32'h0);
         tick();
      end
      sample();
      chk("to_forced_en", 32'(cpu_enable), 32'h1);
      chk("to_forced_io_rd", 32'(io_rd), 32'h02);
      tick();
      drive(16'h0000, 1'b0, 1'b0);
      sample();
      chk("to_di_ff", 32'(cpu_di), 32'hFF);
      chk("to_bus_err", 32'(bus_err), 32'h1);
      chk("to_err_addr", 32'(err_addr), 32'hD100);
      tick();
      err_clr = 1'b1;
      sample();
      chk("to_err_sticky", 32'(bus_err), 32'h1);
      tick();
      err_clr = 1'b0;
      sample();
      chk("to_err_cleared", 32'(bus_err), 32'h0);
      chk("to_di_after", 32'(cpu_di), 32'h00);
      tick();

      // Timeout on a write coinciding with err_clr: timeout wins.
      drive(16'hD1AB, 1'b0, 1'b1);
      for (int c = 0; c < 4; c++) tick();
      err_clr = 1'b1;
      sample();
      chk("tc_forced_en", 32'(cpu_enable), 32'h1);
      chk("tc_io_wr", 32'(io_wr), 32'h02);
      tick();
      err_clr = 1'b0;
      drive(16'h0000, 1'b0, 1'b0);
      sample();
      chk("tc_bus_err", 32'(bus_err), 32'h1);
      chk("tc_err_addr", 32'(err_addr), 32'hD1AB);
      chk("tc_di_ff", 32'(cpu_di), 32'hFF);
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      sample();
      chk("tc_cleared", 32'(bus_err), 32'h0);
      tick();

      // Ack arriving on the cycle the timeout would fire.
      drive(16'hD100, 1'b1, 1'b0);
      for (int c = 0; c < 4; c++) tick();
      io_ack = 8'h02;
      sample();
      chk("at_en", 32'(cpu_enable), 32'h1);
      tick();
      io_ack = 8'h00;
      drive(16'h0000, 1'b0, 1'b0);
      sample();
      chk("at_bus_err", 32'(bus_err), 32'h0);
      chk("at_di", 32'(cpu_di), 32'h31);
      tick();

      // Registered slot 5 returns the byte from the access cycle.
      io_data[47:40] = 8'h11;
      drive(16'hD500, 1'b1, 1'b0);
      tick();
      io_data[47:40] = 8'h22;
      drive(16'h0000, 1'b0, 1'b0);
      sample();
      chk("reg5_di", 32'(cpu_di), 32'h11);
      tick();
      // Unregistered slot 4 shows the live byte.
      io_data[39:32] = 8'h11;
      drive(16'hD400, 1'b1, 1'b0);
      tick();
      io_data[39:32] = 8'h22;
      drive(16'h0000, 1'b0, 1'b0);
      sample();
      chk("live4_di", 32'(cpu_di), 32'h22);
      tick();

      // Reset during WAIT cycle 2 aborts the access without an error.
      drive(16'hD100, 1'b1, 1'b0);
      tick();
      tick();
      sample();
      chk("rw_state_wait", 32'(fsm_state), 32'h1);
      chk("rw_en_pre", 32'(cpu_enable), 32'h0);
      reset = 1'b1;
      #1;
      chk("rw_en", 32'(cpu_enable), 32'h0);
      chk("rw_io_rd", 32'(io_rd), 32'h00);
      chk("rw_bus_err", 32'(bus_err), 32'h0);
      chk("rw_state_rst", 32'(fsm_state), 32'h0);
      tick();
      tick();
      drive(16'h0000, 1'b0, 1'b0);
      reset = 1'b0;
      sample();
      chk("rw_state_after", 32'(fsm_state), 32'h0);
      chk("rw_en_after", 32'(cpu_enable), 32'h1);
      chk("rw_bus_err_after", 32'(bus_err), 32'h0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
